// File: rtl/bg_cmd_scheduler_if.sv
// rtl/bg_cmd_scheduler_if.sv - request and command bus of the bank-group command scheduler
// master drives requests and halt; slave (the scheduler) answers with grants and DRAM commands.
interface bg_cmd_scheduler_if #(
  parameter int NREQ       = 2,
  parameter int BAWIDTH    = 1,
  parameter int ADDRWIDTH  = 17,
  parameter int CADDRWIDTH = 10
);
  logic                            halt;
  logic [NREQ-1:0]                 req;
  logic [NREQ-1:0]                 req_wr;
  logic [NREQ*(BAWIDTH+1)-1:0]     req_ba;
  logic [NREQ*ADDRWIDTH-1:0]       req_row;
  logic [NREQ*CADDRWIDTH-1:0]      req_col;
  logic [NREQ-1:0]                 gnt;
  logic [NREQ-1:0]                 done;
  logic [18:0]                     commands;
  logic [BAWIDTH:0]                ba;
  logic [ADDRWIDTH-1:0]            row;
  logic [CADDRWIDTH-1:0]           column;
  logic                            busy;

  modport master (
    output halt, req, req_wr, req_ba, req_row, req_col,
    input  gnt, done, commands, ba, row, column, busy
  );

  modport slave (
    input  halt, req, req_wr, req_ba, req_row, req_col,
    output gnt, done, commands, ba, row, column, busy
  );
endinterface

// File: rtl/bg_cmd_scheduler.sv
// rtl/bg_cmd_scheduler.sv - round-robin bank-group command scheduler with open-page policy
// Every state's command is registered on the edge that leaves it, so commands lag state by one clock.
module bg_cmd_scheduler #(
  parameter int ADDRWIDTH     = 17,
  parameter int BANKSPERGROUP = 2,
  parameter int COLS          = 1024,
  parameter int BL            = 8,
  parameter int NREQ          = 2,
  parameter int TRCD          = 3,
  parameter int TRP           = 3
) (
  input logic              clk,
  input logic              rst,
  bg_cmd_scheduler_if.slave bus
);
  localparam int BAWIDTH    = $clog2(BANKSPERGROUP);
  localparam int CADDRWIDTH = $clog2(COLS);
  localparam int BW         = BAWIDTH + 1;
  localparam int NBANK      = 1 << BW;
  localparam int PW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WMAX       = (TRCD > TRP) ? TRCD : TRP;
  localparam int CW         = $clog2(WMAX + 1);
  localparam int BEATS      = BL / 2;
  localparam int BCW        = $clog2(BEATS + 1);

  localparam logic [18:0] CMD_ACT = 19'h40000;
  localparam logic [18:0] CMD_PR  = 19'h00080;
  localparam logic [18:0] CMD_RD  = 19'h00020;
  localparam logic [18:0] CMD_WR  = 19'h00002;

  typedef enum logic [2:0] {IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, BURST} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [BCW-1:0]         bcnt;
  logic [PW-1:0]          last;
  logic [PW-1:0]          cur;
  logic                   wr_r;
  logic [NBANK-1:0]       bank_open;
  logic [ADDRWIDTH-1:0]   bank_row [NBANK];

  logic                   found;
  logic [PW-1:0]          win;
  logic [PW-1:0]          cand;
  logic                   w_wr;
  logic [BW-1:0]          w_ba;
  logic [ADDRWIDTH-1:0]   w_row;
  logic [CADDRWIDTH-1:0]  w_col;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(last) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign w_wr  = bus.req_wr[win];
  assign w_ba  = bus.req_ba[int'(win)*BW +: BW];
  assign w_row = bus.req_row[int'(win)*ADDRWIDTH +: ADDRWIDTH];
  assign w_col = bus.req_col[int'(win)*CADDRWIDTH +: CADDRWIDTH];

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bcnt         <= '0;
      last         <= PW'(NREQ - 1);
      cur          <= '0;
      wr_r         <= 1'b0;
      bank_open    <= '0;
      for (int i = 0; i < NBANK; i++) bank_row[i] <= '0;
      bus.gnt      <= '0;
      bus.done     <= '0;
      bus.commands <= '0;
      bus.ba       <= '0;
      bus.row      <= '0;
      bus.column   <= '0;
    end else begin
      bus.gnt      <= '0;
      bus.done     <= '0;
      bus.commands <= '0;
      if (!bus.halt) begin
        case (state)
          IDLE: begin
            if (found) begin
              bus.gnt[win] <= 1'b1;
              last         <= win;
              cur          <= win;
              wr_r         <= w_wr;
              bus.ba       <= w_ba;
              bus.row      <= w_row;
              bus.column   <= w_col;
              if (!bank_open[w_ba])             state <= ACT;
              else if (bank_row[w_ba] == w_row) state <= BURST;
              else                              state <= PRE;
            end
          end
          PRE: begin
            bus.commands      <= CMD_PR;
            bank_open[bus.ba] <= 1'b0;
            if (TRP <= 1) begin
              state <= ACT;
            end else begin
              cnt   <= CW'(TRP - 2);
              state <= WAIT_RP;
            end
          end
          WAIT_RP: begin
            if (cnt == '0) state <= ACT;
            else           cnt   <= cnt - 1'b1;
          end
          ACT: begin
            bus.commands      <= CMD_ACT;
            bank_open[bus.ba] <= 1'b1;
            bank_row[bus.ba]  <= bus.row;
            if (TRCD <= 1) begin
              state <= BURST;
            end else begin
              cnt   <= CW'(TRCD - 2);
              state <= WAIT_RCD;
            end
          end
          WAIT_RCD: begin
            if (cnt == '0) state <= BURST;
            else           cnt   <= cnt - 1'b1;
          end
          BURST: begin
            bus.commands <= wr_r ? CMD_WR : CMD_RD;
            if (bcnt == BCW'(BEATS - 1)) begin
              bcnt          <= '0;
              bus.done[cur] <= 1'b1;
              state         <= IDLE;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bg_cmd_scheduler.sv
// tb/tb_bg_cmd_scheduler.sv - scoreboard bench for bg_cmd_scheduler
// Stimulus pushes expected commands/dones per grant; a negedge monitor pops and compares.
module tb_bg_cmd_scheduler;
  localparam int TRCD  = 3;
  localparam int TRP   = 3;
  localparam int BEATS = 4;
  localparam logic [18:0] C_ACT = 19'h40000;
  localparam logic [18:0] C_PR  = 19'h00080;
  localparam logic [18:0] C_RD  = 19'h00020;
  localparam logic [18:0] C_WR  = 19'h00002;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bg_cmd_scheduler_if #(.NREQ(2), .BAWIDTH(1), .ADDRWIDTH(17), .CADDRWIDTH(10)) bus();

  bg_cmd_scheduler #(
    .ADDRWIDTH(17), .BANKSPERGROUP(2), .COLS(1024), .BL(8), .NREQ(2), .TRCD(TRCD), .TRP(TRP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int          cyc;
    logic [18:0] cmd;
    logic [1:0]  ba;
    logic [16:0] row;
    logic [9:0]  col;
  } ev_t;

  typedef struct {
    int         cyc;
    logic [1:0] mask;
  } dn_t;

  ev_t         exp_q[$];
  dn_t         done_q[$];
  int          cycle  = 0;
  int          checks = 0;
  int          errors = 0;
  bit          busy_model = 1'b0;
  bit          m_open [4];
  logic [16:0] m_row  [4];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cycle);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    dn_t d;
    if (rst) begin
      if (bus.commands != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", 64'(bus.commands), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("cmd_cycle", 64'(cycle), 64'(e.cyc));
          check("cmd", 64'(bus.commands), 64'(e.cmd));
          check("cmd_ba", 64'(bus.ba), 64'(e.ba));
          check("cmd_row", 64'(bus.row), 64'(e.row));
          check("cmd_col", 64'(bus.column), 64'(e.col));
        end
      end
      if (bus.done != '0) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 64'(bus.done), 64'd0);
        end else begin
          d = done_q.pop_front();
          check("done_cycle", 64'(cycle), 64'(d.cyc));
          check("done_mask", 64'(bus.done), 64'(d.mask));
        end
        busy_model = 1'b0;
      end
      if (bus.gnt != '0) begin
        check("gnt_while_busy", 64'(busy_model), 64'd0);
        busy_model = 1'b1;
      end
    end else begin
      busy_model = 1'b0;
    end
  end

  // Expected timing derived from the grant cycle t and the bench's own bank model.
  task automatic push_txn(input int t, input int idx, input bit wr, input logic [1:0] ba,
                          input logic [16:0] row, input logic [9:0] col, input int beats,
                          input int shift);
    ev_t e;
    dn_t d;
    int  s;
    e.ba = ba; e.row = row; e.col = col;
    if (m_open[ba] && m_row[ba] == row) begin
      s = t + 1;
    end else begin
      if (m_open[ba]) begin
        e.cyc = t + 1; e.cmd = C_PR; exp_q.push_back(e);
        e.cyc = t + 1 + TRP;
      end else begin
        e.cyc = t + 1;
      end
      e.cmd = C_ACT; exp_q.push_back(e);
      s = e.cyc + TRCD;
    end
    m_open[ba] = 1'b1;
    m_row[ba]  = row;
    for (int k = 0; k < beats; k++) begin
      e.cyc = s + shift + k;
      e.cmd = wr ? C_WR : C_RD;
      exp_q.push_back(e);
    end
    if (beats == BEATS) begin
      d.cyc  = s + shift + BEATS - 1;
      d.mask = 2'(1 << idx);
      done_q.push_back(d);
    end
  endtask

  task automatic wait_gnt(output int t, output int idx);
    t = -1; idx = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        t   = cycle;
        idx = bus.gnt[1] ? 1 : 0;
        check("gnt_onehot", 64'($countones(bus.gnt)), 64'd1);
        break;
      end
    end
    if (t < 0) begin
      checks++; errors++;
      $display("FAIL gnt_timeout: got no grant expected one within 60 cycles");
    end
  endtask

  task automatic set_fields(input int idx, input bit wr, input logic [1:0] ba,
                            input logic [16:0] row, input logic [9:0] col);
    bus.req_wr[idx]          = wr;
    bus.req_ba[idx*2 +: 2]   = ba;
    bus.req_row[idx*17 +: 17] = row;
    bus.req_col[idx*10 +: 10] = col;
  endtask

  task automatic single(input int idx, input bit wr, input logic [1:0] ba,
                        input logic [16:0] row, input logic [9:0] col, input bit do_halt);
    int t, g;
    set_fields(idx, wr, ba, row, col);
    bus.req[idx] = 1'b1;
    wait_gnt(t, g);
    bus.req[idx] = 1'b0;
    if (t >= 0) begin
      check("gnt_idx", 64'(g), 64'(idx));
      push_txn(t, idx, wr, ba, row, col, BEATS, do_halt ? 3 : 0);
      if (do_halt) begin
        @(negedge clk);
        bus.halt = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("halt_cmd_zero", 64'(bus.commands), 64'd0);
          check("halt_busy", 64'(bus.busy), 64'd1);
        end
        bus.halt = 1'b0;
      end
    end
  endtask

  task automatic run_both(input int n, input int first);
    int t, g, expi;
    set_fields(0, 1'b0, 2'd0, 17'd2, 10'h11);
    set_fields(1, 1'b1, 2'd1, 17'd3, 10'h22);
    bus.req = 2'b11;
    expi = first;
    for (int k = 0; k < n; k++) begin
      wait_gnt(t, g);
      if (t < 0) break;
      check("rr_order", 64'(g), 64'(expi));
      if (g == 1) push_txn(t, 1, 1'b1, 2'd1, 17'd3, 10'h22, BEATS, 0);
      else        push_txn(t, 0, 1'b0, 2'd0, 17'd2, 10'h11, BEATS, 0);
      expi = 1 - expi;
    end
    bus.req = 2'b00;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d commands and %0d dones outstanding expected 0",
               exp_q.size(), done_q.size());
      exp_q.delete();
      done_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int t, g;
    bus.halt = 1'b0; bus.req = '0; bus.req_wr = '0;
    bus.req_ba = '0; bus.req_row = '0; bus.req_col = '0;
    for (int i = 0; i < 4; i++) begin m_open[i] = 1'b0; m_row[i] = '0; end

    repeat (3) @(negedge clk);
    check("rst_commands", 64'(bus.commands), 64'd0);
    check("rst_gnt", 64'(bus.gnt), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_ba", 64'(bus.ba), 64'd0);
    check("rst_row", 64'(bus.row), 64'd0);
    check("rst_column", 64'(bus.column), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    single(0, 1'b1, 2'd0, 17'd1, 10'd1, 1'b0); drain();   // closed bank write
    single(0, 1'b0, 2'd0, 17'd1, 10'd5, 1'b0); drain();   // row hit
    single(0, 1'b0, 2'd0, 17'd2, 10'd7, 1'b0); drain();   // row miss
    single(1, 1'b1, 2'd1, 17'd3, 10'd9, 1'b1); drain();   // halt in WAIT_RCD
    run_both(4, 0); drain();

    // Reset two beats into a row-hit write burst.
    set_fields(0, 1'b1, 2'd0, 17'd2, 10'h33);
    bus.req[0] = 1'b1;
    wait_gnt(t, g);
    bus.req[0] = 1'b0;
    if (t >= 0) begin
      check("gnt_idx", 64'(g), 64'd0);
      push_txn(t, 0, 1'b1, 2'd0, 17'd2, 10'h33, 2, 0);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_mid_commands", 64'(bus.commands), 64'd0);
      check("rst_mid_busy", 64'(bus.busy), 64'd0);
      check("rst_mid_done", 64'(bus.done), 64'd0);
      check("rst_mid_row", 64'(bus.row), 64'd0);
      @(negedge clk);
      #2 rst = 1'b1;
      for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
      @(negedge clk);
    end
    run_both(2, 0); drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bg_cmd_scheduler.md
BG_CMD_SCHEDULER -- requirements
Module: bg_cmd_scheduler

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDRWIDTH, 17, row address width.
- BANKSPERGROUP, 2, banks in the group; BAWIDTH = $clog2(BANKSPERGROUP).
- COLS, 1024, columns per row; CADDRWIDTH = $clog2(COLS).
- BL, 8, burst length; a burst occupies BL/2 clocks.
- NREQ, 2, number of requesters.
- TRCD, 3, clocks from ACT to first RD/WR (minimum 1).
- TRP, 3, clocks from PR to ACT (minimum 1).

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock; all logic on the rising edge.
- rst, in, 1, reset; asynchronous, active-low.
- halt, in, 1, freeze request.
- req, in, NREQ, per-requester request, held high until gnt.
- req_wr, in, NREQ, per-requester operation: 1 = write, 0 = read.
- req_ba, in, NREQ*(BAWIDTH+1), packed bank addresses; requester i occupies slice i.
- req_row, in, NREQ*ADDRWIDTH, packed row addresses.
- req_col, in, NREQ*CADDRWIDTH, packed column addresses.
- gnt, out, NREQ, one-clock acceptance pulse.
- done, out, NREQ, one-clock pulse on the last burst clock.
- commands, out, 19, one-hot bank-group command: bit18 ACT, bit7 PR, bit5 RD, bit1 WR; all other bits always 0.
- ba, out, BAWIDTH+1, bank address.
- row, out, ADDRWIDTH, row address.
- column, out, CADDRWIDTH, column address.
- busy, out, 1, high when the FSM is not in IDLE.

Function
REQ-003 FSM states: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, BURST.
REQ-004 Arbitration happens only in IDLE with halt low and any req high.
- Arbitration is round-robin, starting the search at (last granted + 1) mod NREQ.
- The pointer resets so requester 0 has first priority.
REQ-005 On acceptance, the scheduler:
- pulses gnt[i] for one clock;
- latches wr, ba, row and column from requester i.
REQ-006 Per-bank tracking: each bank holds an open flag and an open-row register; all banks are closed at reset.
REQ-007 Next state after acceptance depends on the latched bank:
- bank open with the latched row (hit): BURST;
- bank closed: ACT;
- bank open with another row (miss): PRE.
REQ-008 State timing; grant cycle is T:
- hit: first RD/WR at T+1;
- closed bank: ACT at T+1, first RD/WR at T+1+TRCD;
- miss: PR at T+1, ACT at T+1+TRP, first RD/WR at T+1+TRP+TRCD.
REQ-009 PRE and ACT each drive their command bit for exactly one clock.
- PRE clears the bank's open flag.
- ACT sets the bank's open flag and loads its open-row register.
- WAIT_RP and WAIT_RCD use a down-counter and drive commands = 0.
REQ-010 BURST behaviour:
- drive WR or RD continuously for BL/2 clocks with ba, row and column held;
- pulse done[i] on the final clock;
- return to IDLE; a new grant is possible on the next clock.
- The row stays open after the burst (open-page policy).
REQ-011 Outside PRE, ACT and BURST: commands = 0.
- ba, row and column hold their last value at all times; they reset to 0.
REQ-012 When halt is high, it freezes the FSM state, wait counters and burst counter.
- It also forces commands = 0 and inhibits new grants.
- When halt drops, operation resumes where it stopped; the interrupted command is reissued for its remaining clocks.
REQ-013 A requester must hold its request fields stable while req is high; no req ever yields a grant.
REQ-014 A second request from the same requester is accepted only after its done.

Reset
REQ-015 When rst is low, asynchronously:
- FSM goes to IDLE;
- commands, gnt, done and busy go to 0;
- ba, row and column go to 0;
- all banks are marked closed;
- counters clear and the round-robin pointer resets.
REQ-016 Reset mid-operation abandons the transaction; no done is issued for it.

Verification
REQ-017 Closed bank:
- stimulus: req0 write, ba=0, row=1, col=1, granted at T;
- response: ACT at T+1, WR bits high T+4..T+7, done[0] at T+7.
REQ-018 Row hit:
- stimulus: after REQ-017, req0 read with ba=0, row=1;
- response: RD at grant+1 for 4 clocks, no PR or ACT.
REQ-019 Row miss:
- stimulus: read with ba=0, row=2;
- response: PR at T+1, ACT at T+4, RD T+7..T+10, bank 0 open row becomes 2.
REQ-020 Arbitration:
- stimulus: req0 and req1 both held continuously;
- response: grants alternate 0,1,0,1; no gnt while busy.
REQ-021 Halt:
- stimulus: halt for 3 clocks during WAIT_RCD;
- response: commands = 0 while halted, RD/WR first clock shifted later by exactly 3.
REQ-022 Reset during burst:
- stimulus: rst low for 1 clock mid-BURST;
- response: commands = 0 immediately, no done, next access to that bank issues ACT.
